// File: rtl/spi_pkg.sv
// spi_pkg -- shared definitions for the SPI main controller and any
// subordinate model that talks to it.
//   * frame mode encodings and the frame lengths they select
//   * RX_BITS: number of leading received bits kept in rx_data
//   * FSM state enum for spi_main
//   * frame_len(): mode -> frame length in bits
package spi_pkg;

    localparam int FRAME_W = 258;  // widest frame, tx_data is left-aligned to this
    localparam int RX_BITS = 128;
    localparam int CNT_W   = 9;    // bit counter width, holds 0..257

    localparam logic [CNT_W-1:0] LEN_130 = 9'd130;
    localparam logic [CNT_W-1:0] LEN_198 = 9'd198;
    localparam logic [CNT_W-1:0] LEN_258 = 9'd258;

    typedef enum logic [1:0] {
        MODE_130 = 2'b00,
        MODE_198 = 2'b01,
        MODE_258 = 2'b10,
        MODE_ILL = 2'b11
    } mode_e;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        FLUSH,
        FIN
    } state_e;

    // The illegal mode never reaches a frame; it maps to the shortest length
    // only so the function is total.
    function automatic logic [CNT_W-1:0] frame_len(input logic [1:0] mode);
        case (mode)
            MODE_198: frame_len = LEN_198;
            MODE_258: frame_len = LEN_258;
            default:  frame_len = LEN_130;
        endcase
    endfunction

endpackage

// File: rtl/spi_main_if.sv
// spi_main_if -- host-side request/response bundle of spi_main.
//   start    : single-cycle transfer request
//   mode     : frame length select (00=130, 01=198, 10=258, 11=illegal)
//   tx_data  : frame, left-aligned, bit 257 sent first
//   busy     : transfer in progress
//   done     : one-cycle pulse at transfer end
//   err      : one-cycle pulse on a start with the illegal mode
//   rx_data  : first 128 received bits, first bit in bit 127
// modport master = requester, modport slave = spi_main.
interface spi_main_if;
    import spi_pkg::*;

    logic                 start;
    logic [1:0]           mode;
    logic [FRAME_W-1:0]   tx_data;
    logic                 busy;
    logic                 done;
    logic                 err;
    logic [RX_BITS-1:0]   rx_data;

    modport master (
        output start, mode, tx_data,
        input  busy, done, err, rx_data
    );

    modport slave (
        input  start, mode, tx_data,
        output busy, done, err, rx_data
    );

endinterface

// File: rtl/spi_clk_gen.sv
// spi_clk_gen -- serial clock divider.
//   clk, rst : system clock, async active-high reset
//   en       : run the divider; while low sclk is held low and the count cleared
//   sclk     : divided clock, toggles every CLK_DIV clk cycles while enabled
//   rise     : high in the clk cycle whose closing edge drives sclk 0->1
//   fall     : high in the clk cycle whose closing edge drives sclk 1->0
// The strobes lead the edge so the owner can update data on the very same
// clk edge that moves sclk.
module spi_clk_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic sclk,
    output logic rise,
    output logic fall
);

    logic [7:0] cnt;
    logic       tick;

    assign tick = en && (cnt == 8'(CLK_DIV - 1));
    assign rise = tick && !sclk;
    assign fall = tick && sclk;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            sclk <= 1'b0;
        end else if (!en) begin
            cnt  <= '0;
            sclk <= 1'b0;
        end else if (tick) begin
            cnt  <= '0;
            sclk <= ~sclk;
        end else begin
            cnt  <= cnt + 8'd1;
        end
    end

endmodule

// File: rtl/spi_main.sv
// spi_main -- SPI main controller for 130/198/258-bit frames.
//   clk, rst : system clock, async active-high reset
//   host     : request/response bundle (spi_main_if.slave)
//   cs_n     : chip select, active low
//   sclk     : serial clock, idles low, CLK_DIV clk cycles per half-period
//   mosi     : serial out, changes on sclk rise, stable at the sampling fall
//   miso     : serial in, sampled on sclk fall
// Frame: SETUP (cs_n low, sclk low) -> SHIFT (N sclk periods) -> HOLD
// (sclk low, cs_n low) -> FLUSH (one sclk pulse with cs_n high, mosi low)
// -> FIN (done pulse).
module spi_main
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic          clk,
    input  logic          rst,
    spi_main_if.slave     host,
    output logic          cs_n,
    output logic          sclk,
    output logic          mosi,
    input  logic          miso
);

    state_e               state;
    logic [FRAME_W-1:0]   shreg;
    logic [1:0]           frame_mode;
    logic [CNT_W-1:0]     bit_cnt;
    logic [CNT_W-1:0]     last_bit;
    logic [7:0]           hold_cnt;
    logic [RX_BITS-1:0]   rx;
    logic                 busy;
    logic                 done;
    logic                 err;
    logic                 clk_en;
    logic                 sclk_rise;
    logic                 sclk_fall;

    assign host.busy    = busy;
    assign host.done    = done;
    assign host.err     = err;
    assign host.rx_data = rx;

    assign last_bit = frame_len(frame_mode) - 9'd1;

    // SETUP's low time is the low half before the first rise, so the divider
    // already runs there; HOLD times itself because sclk must stay low.
    assign clk_en = (state == SETUP) || (state == SHIFT) || (state == FLUSH);

    spi_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (clk_en),
        .sclk (sclk),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            shreg      <= '0;
            frame_mode <= MODE_130;
            bit_cnt    <= '0;
            hold_cnt   <= '0;
            rx         <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            cs_n       <= 1'b1;
            mosi       <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (host.start) begin
                        if (host.mode == MODE_ILL) begin
                            err <= 1'b1;
                        end else begin
                            shreg      <= host.tx_data;
                            frame_mode <= host.mode;
                            bit_cnt    <= '0;
                            busy       <= 1'b1;
                            cs_n       <= 1'b0;
                            state      <= SETUP;
                        end
                    end
                end

                SETUP: begin
                    // first rise carries frame bit 0
                    if (sclk_rise) begin
                        mosi  <= shreg[FRAME_W-1];
                        shreg <= {shreg[FRAME_W-2:0], 1'b0};
                        state <= SHIFT;
                    end
                end

                SHIFT: begin
                    if (sclk_rise) begin
                        mosi  <= shreg[FRAME_W-1];
                        shreg <= {shreg[FRAME_W-2:0], 1'b0};
                    end
                    if (sclk_fall) begin
                        if (bit_cnt < 9'(RX_BITS))
                            rx <= {rx[RX_BITS-2:0], miso};
                        // stop on the last fall so the counter never wraps
                        if (bit_cnt == last_bit) begin
                            hold_cnt <= '0;
                            state    <= HOLD;
                        end else begin
                            bit_cnt  <= bit_cnt + 9'd1;
                        end
                    end
                end

                HOLD: begin
                    // mosi keeps the last bit through HOLD; it drops together
                    // with cs_n, never on an sclk edge
                    if (hold_cnt == 8'(CLK_DIV - 1)) begin
                        cs_n  <= 1'b1;
                        mosi  <= 1'b0;
                        state <= FLUSH;
                    end else begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end

                FLUSH: begin
                    if (sclk_fall) begin
                        done  <= 1'b1;
                        state <= FIN;
                    end
                end

                FIN: begin
                    // a start seen here is dropped: IDLE is not entered yet
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_main.sv
// tb_spi_main -- directed self-checking bench for spi_main (CLK_DIV=2).
// A subordinate model watches sclk/cs_n from the falling clk edge: it drives
// miso after each sclk rise, captures mosi at each sclk fall and counts
// falls with cs_n low/high plus every sclk edge.
// Cycle count of a frame = cycles from the start cycle to the done cycle
// inclusive: 2*D (SETUP+first high) per first bit, 2*D*N for the bits,
// D HOLD, 2*D FLUSH, one done cycle -> 2DN+3D+2; D=2 gives
// N=130:528, N=198:800, N=258:1040.
module tb_spi_main;
    import spi_pkg::*;

    localparam int D = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cs_n, sclk, mosi;
    logic miso = 1'b0;

    spi_main_if bus();

    spi_main #(.CLK_DIV(D)) dut (
        .clk  (clk),
        .rst  (rst),
        .host (bus),
        .cs_n (cs_n),
        .sclk (sclk),
        .mosi (mosi),
        .miso (miso)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // subordinate model
    logic [127:0]       miso_pat = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
    logic [FRAME_W-1:0] cap = '0;
    int                 falls_lo = 0;
    int                 falls_hi = 0;
    int                 edges = 0;
    int                 rise_k = 0;
    logic               sclk_prev = 1'b0;
    logic               cs_prev = 1'b1;

    always @(negedge clk) begin
        if (cs_prev && !cs_n) begin
            falls_lo <= 0;
            falls_hi <= 0;
            cap      <= '0;
            rise_k   <= 0;
        end else begin
            if (sclk && !sclk_prev) begin
                edges <= edges + 1;
                if (!cs_n) begin
                    miso   <= (rise_k < RX_BITS) ? miso_pat[RX_BITS-1-rise_k] : 1'b0;
                    rise_k <= rise_k + 1;
                end
            end
            if (!sclk && sclk_prev) begin
                edges <= edges + 1;
                if (!cs_n) begin
                    if (falls_lo < FRAME_W) cap[FRAME_W-1-falls_lo] <= mosi;
                    falls_lo <= falls_lo + 1;
                end else begin
                    falls_hi <= falls_hi + 1;
                end
            end
        end
        sclk_prev <= sclk;
        cs_prev   <= cs_n;
    end

    // Issue one frame and wait for done; returns at the done cycle.
    // noise: toggle tx_data/mode every cycle and pulse start while busy.
    task automatic do_frame(input logic [1:0] m, input logic [FRAME_W-1:0] tx,
                            input bit noise, output int n, output logic busy1);
        @(negedge clk);
        bus.start = 1'b1; bus.mode = m; bus.tx_data = tx;
        @(negedge clk);
        bus.start = 1'b0;
        busy1 = bus.busy;
        n = 1;
        while (bus.done !== 1'b1 && n < 4000) begin
            @(negedge clk);
            n++;
            if (noise) begin
                bus.tx_data = ~bus.tx_data;
                bus.mode    = n[0] ? 2'b10 : 2'b11;
                bus.start   = (n == 20 || n == 21);
            end
        end
        bus.start = 1'b0;
    endtask

    function automatic logic [FRAME_W-1:0] sent_bits(input logic [FRAME_W-1:0] tx, input int len);
        logic [FRAME_W-1:0] ones;
        ones = '1;
        return tx & ~(ones >> len);
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({cs_n, sclk, mosi, bus.busy, bus.done, bus.err} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_outs got=%b want=100000", {cs_n, sclk, mosi, bus.busy, bus.done, bus.err});
        end
        checks++;
        if (bus.rx_data !== 128'h0) begin
            errors++; $display("FAIL reset_rx got=%h want=0", bus.rx_data);
        end
        rst = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (edges !== 0 || sclk !== 1'b0) begin
            errors++; $display("FAIL reset_release_edges got=%0d want=0", edges);
        end
    endtask

    task automatic test_mode00();
        logic [FRAME_W-1:0] tx;
        int n; logic b1;
        tx = {2'b00, 128'h0123456789ABCDEF0011223344556677, 128'hA5A5A5A5_5A5A5A5A_FFFF0000_0000FFFF};
        do_frame(2'b00, tx, 1'b0, n, b1);
        checks++;
        if (b1 !== 1'b1) begin errors++; $display("FAIL m00_busy got=%b want=1", b1); end
        checks++;
        if (n + 1 != 528) begin errors++; $display("FAIL m00_cycles got=%0d want=528", n + 1); end
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || cs_n !== 1'b1) begin
            errors++; $display("FAIL m00_end busy=%b done=%b cs_n=%b want 0 0 1", bus.busy, bus.done, cs_n);
        end
        checks++;
        if (falls_lo != 130 || falls_hi != 1) begin
            errors++; $display("FAIL m00_falls got=%0d/%0d want=130/1", falls_lo, falls_hi);
        end
        checks++;
        if (cap !== sent_bits(tx, 130)) begin
            errors++; $display("FAIL m00_mosi got=%h want=%h", cap, sent_bits(tx, 130));
        end
        checks++;
        if (bus.rx_data !== 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF) begin
            errors++; $display("FAIL m00_rx got=%h want=deadbeefcafef00d0123456789abcdef", bus.rx_data);
        end
    endtask

    task automatic test_frame_lengths();
        logic [FRAME_W-1:0] txs [2];
        logic [1:0]         modes [2] = '{2'b01, 2'b10};
        int                 lens [2]  = '{198, 258};
        int                 cycs [2]  = '{800, 1040};
        int n; logic b1;
        txs[0] = {2'b01, 128'hFEDCBA98_76543210_13579BDF_2468ACE0, 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0};
        txs[1] = {2'b10, 128'h80000000_00000001_C0FFEE00_12345678, 128'hAAAAAAAA_55555555_00FF00FF_F0F0F0F1};
        miso_pat = 128'h13572468_9ABCDEF0_FFFFFFFF_00000001;
        for (int i = 0; i < 2; i++) begin
            do_frame(modes[i], txs[i], 1'b0, n, b1);
            checks++;
            if (n + 1 != cycs[i]) begin
                errors++; $display("FAIL len%0d_cycles got=%0d want=%0d", lens[i], n + 1, cycs[i]);
            end
            @(negedge clk);
            checks++;
            if (falls_lo != lens[i] || falls_hi != 1) begin
                errors++; $display("FAIL len%0d_falls got=%0d/%0d want=%0d/1", lens[i], falls_lo, falls_hi, lens[i]);
            end
            checks++;
            if (cap !== sent_bits(txs[i], lens[i])) begin
                errors++; $display("FAIL len%0d_mosi got=%h want=%h", lens[i], cap, sent_bits(txs[i], lens[i]));
            end
            checks++;
            if (bus.rx_data !== 128'h13572468_9ABCDEF0_FFFFFFFF_00000001) begin
                errors++; $display("FAIL len%0d_rx got=%h want=135724689abcdef0ffffffff00000001", lens[i], bus.rx_data);
            end
        end
    endtask

    task automatic test_illegal();
        int e0;
        @(negedge clk);
        e0 = edges;
        bus.start = 1'b1; bus.mode = 2'b11; bus.tx_data = '1;
        @(negedge clk);
        bus.start = 1'b0;
        checks++;
        if (bus.err !== 1'b1 || bus.busy !== 1'b0 || cs_n !== 1'b1) begin
            errors++; $display("FAIL ill_pulse err=%b busy=%b cs_n=%b want 1 0 1", bus.err, bus.busy, cs_n);
        end
        @(negedge clk);
        checks++;
        if (bus.err !== 1'b0) begin errors++; $display("FAIL ill_err_width got=%b want=0", bus.err); end
        repeat (20) @(negedge clk);
        checks++;
        if (edges != e0 || cs_n !== 1'b1 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL ill_idle edges=%0d want=%0d cs_n=%b busy=%b", edges, e0, cs_n, bus.busy);
        end
    endtask

    task automatic test_reset_mid();
        logic [FRAME_W-1:0] tx;
        int k, e0, n; logic b1;
        tx = {2'b10, 128'h11112222_33334444_55556666_77778888, 128'h9999AAAA_BBBBCCCC_DDDDEEEE_FFFF0000};
        miso_pat = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
        @(negedge clk);
        bus.start = 1'b1; bus.mode = 2'b10; bus.tx_data = tx;
        @(negedge clk);
        bus.start = 1'b0;
        k = 0;
        while (falls_lo < 60 && k < 2000) begin @(negedge clk); k++; end
        checks++;
        if (falls_lo < 60) begin errors++; $display("FAIL rmid_reach got=%0d want>=60", falls_lo); end
        rst = 1'b1;
        #1;
        checks++;
        if ({cs_n, sclk, mosi, bus.busy, bus.done} !== 5'b10000 || bus.rx_data !== 128'h0) begin
            errors++; $display("FAIL rmid_async got=%b rx=%h want=10000 rx=0",
                               {cs_n, sclk, mosi, bus.busy, bus.done}, bus.rx_data);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        e0 = edges;
        repeat (6) @(negedge clk);
        checks++;
        if (edges != e0 || cs_n !== 1'b1) begin
            errors++; $display("FAIL rmid_quiet edges=%0d want=%0d cs_n=%b", edges, e0, cs_n);
        end
        do_frame(2'b10, tx, 1'b0, n, b1);
        checks++;
        if (n + 1 != 1040) begin errors++; $display("FAIL rmid_cycles got=%0d want=1040", n + 1); end
        @(negedge clk);
        checks++;
        if (falls_lo != 258 || falls_hi != 1 || cap !== tx) begin
            errors++; $display("FAIL rmid_frame falls=%0d/%0d cap=%h want=258/1 %h", falls_lo, falls_hi, cap, tx);
        end
        checks++;
        if (bus.rx_data !== 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF) begin
            errors++; $display("FAIL rmid_rx got=%h want=deadbeefcafef00d0123456789abcdef", bus.rx_data);
        end
    endtask

    task automatic test_busy_ignore();
        logic [FRAME_W-1:0] tx;
        int n; logic b1;
        tx = {2'b00, 128'hC3C3C3C3_3C3C3C3C_0F0F0F0F_F0F0F0F0, 128'h0};
        do_frame(2'b00, tx, 1'b1, n, b1);
        checks++;
        if (n + 1 != 528) begin errors++; $display("FAIL busy_cycles got=%0d want=528", n + 1); end
        @(negedge clk);
        checks++;
        if (falls_lo != 130 || cap !== sent_bits(tx, 130)) begin
            errors++; $display("FAIL busy_frame falls=%0d cap=%h want=130 %h", falls_lo, cap, sent_bits(tx, 130));
        end
    endtask

    task automatic test_back_to_back();
        logic [FRAME_W-1:0] txa, txb, txc;
        int n; logic b1;
        txa = {2'b00, 128'h01010101_02020202_03030303_04040404, 128'h0};
        txb = {2'b01, 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, 128'hFFFF};
        txc = {2'b00, 128'h89ABCDEF_01234567_76543210_FEDCBA98, 128'h0};
        do_frame(2'b00, txa, 1'b0, n, b1);
        // done cycle: this start must be dropped
        bus.start = 1'b1; bus.mode = 2'b01; bus.tx_data = txb;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || falls_lo != 130 || cap !== sent_bits(txa, 130)) begin
            errors++; $display("FAIL b2b_first busy=%b falls=%0d cap=%h want 0 130 %h",
                               bus.busy, falls_lo, cap, sent_bits(txa, 130));
        end
        // first idle cycle: this start is taken
        bus.start = 1'b1; bus.mode = 2'b00; bus.tx_data = txc;
        @(negedge clk);
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_accept busy=%b want=1", bus.busy); end
        n = 1;
        while (bus.done !== 1'b1 && n < 4000) begin @(negedge clk); n++; end
        checks++;
        if (n + 1 != 528) begin errors++; $display("FAIL b2b_cycles got=%0d want=528", n + 1); end
        @(negedge clk);
        checks++;
        if (falls_lo != 130 || falls_hi != 1 || cap !== sent_bits(txc, 130)) begin
            errors++; $display("FAIL b2b_second falls=%0d/%0d cap=%h want=130/1 %h",
                               falls_lo, falls_hi, cap, sent_bits(txc, 130));
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.mode = 2'b00;
        bus.tx_data = '0;
        test_reset();
        test_mode00();
        test_frame_lengths();
        test_illegal();
        test_reset_mid();
        test_busy_ignore();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/spi_main.md
SPI_MAIN -- requirements
Module: spi_main

Interface
REQ-001 Parameter CLK_DIV, default 2, clk cycles per sclk half-period (legal 1..255).
REQ-002 clk  in  1  system clock; all logic on its rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 start  in  1  single-cycle request; accepted only while busy=0.
REQ-005 mode  in  2  frame length select: 00=130 bits, 01=198 bits, 10=258 bits, 11=illegal.
REQ-006 tx_data  in  258  frame, left-aligned; bit 257 is sent first; bits 257:256 carry the mode header.
REQ-007 busy  out  1  high from the accepting cycle until the done pulse.
REQ-008 done  out  1  one-cycle pulse at transfer end.
REQ-009 err  out  1  one-cycle pulse when start arrives with mode=11.
REQ-010 rx_data  out  128  first 128 bits received on miso, first bit in bit 127.
REQ-011 cs_n  out  1  chip select, active low.
REQ-012 sclk  out  1  serial clock, idles low.
REQ-013 mosi  out  1  serial data to subordinate.
REQ-014 miso  in  1  serial data from subordinate.

Function
REQ-015 FSM states: IDLE, SETUP, SHIFT, HOLD, FLUSH, FIN.
REQ-016 IDLE: start with mode!=11 -> latch tx_data, mode and length N, set busy, enter SETUP; start with mode=11 -> err pulse, stay in IDLE.
REQ-017 SETUP: cs_n=0, sclk=0 for CLK_DIV cycles, then SHIFT.
REQ-018 SHIFT: exactly N sclk periods, each CLK_DIV cycles high then CLK_DIV cycles low.
REQ-019 mosi updates on each sclk rising edge with the next frame bit (bit k of N on rising edge k), so it is stable at the falling edge where the subordinate samples.
REQ-020 miso sampled on each sclk falling edge; samples 0..127 shift into rx_data; samples beyond 127 are discarded.
REQ-021 After the Nth falling edge -> HOLD: sclk=0, cs_n=0 for CLK_DIV cycles, then cs_n=1 -> FLUSH.
REQ-022 FLUSH: one full sclk pulse with cs_n=1 and mosi=0, clearing subordinate bit counters, then FIN.
REQ-023 FIN: done=1 for one cycle, busy=0 on the following cycle, rx_data stable until the next accepted start, return to IDLE.
REQ-024 Bit counter is 9 bits wide, counts 0..N-1, and never wraps within a frame.
REQ-025 start while busy=1 is ignored; tx_data/mode changes while busy do not affect the transfer in progress.
REQ-026 start in the same cycle as the done pulse is ignored; start on the next cycle is accepted.

Reset
REQ-027 rst asserted at any time, including mid-frame, forces IDLE, cs_n=1, sclk=0, mosi=0, busy=0, done=0, err=0, rx_data=0, counters=0 within the same cycle.
REQ-028 No sclk edge is generated while rst is high or in the cycle rst deasserts.

Structure
REQ-029 A shared package spi_pkg holds: mode encodings, frame lengths 130/198/258, RX_BITS=128, and the FSM state enum; the subordinate block uses the same package.
REQ-030 Sub-module spi_clk_gen, a CLK_DIV divider with enable, provides sclk plus one-cycle rise and fall strobes; spi_main owns the FSM and shift registers.

Verification
REQ-031 mode=00, tx_data[257:128]=2'b00 followed by 128'h0123456789ABCDEF0011223344556677, CLK_DIV=2 -> 130 sclk periods, mosi stream matches bit for bit, done after 130*4+2*2+4 clk cycles plus FSM overhead, as checked by the model.
REQ-032 Subordinate model drives miso=128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF -> rx_data equals that value at done.
REQ-033 mode=01 and mode=10 -> exactly 198 and 258 falling edges while cs_n=0, plus one FLUSH pulse with cs_n=1.
REQ-034 start with mode=11 -> err pulse, cs_n stays 1, no sclk edges, busy stays 0.
REQ-035 rst asserted at bit 60 of a 258-bit frame -> cs_n=1, sclk=0 immediately; the next start completes a full, correct frame.
REQ-036 start pulses during busy and in the done cycle -> ignored; back-to-back start on the cycle after done -> second frame is correct.
